// File: rtl/mem_dump_tx_if.sv
// ----------------------------------------------------------------------------
// mem_dump_tx_if
// Read-port bundle between the memory dumper and a spare synchronous read
// port of the data memory. Signal names are seen from the dumper's side.
//   o_ren    : read enable, one cycle per word
//   o_raddr  : word address of the read
//   i_rdata  : read data, valid the cycle after o_ren
// Modports: master = dumper, slave = memory.
// ----------------------------------------------------------------------------
interface mem_dump_tx_if #(
   parameter int AW = 10
);
   logic          o_ren;
   logic [AW-1:0] o_raddr;
   logic [31:0]   i_rdata;

   modport master (
      output o_ren,
      output o_raddr,
      input  i_rdata
   );

   modport slave (
      input  o_ren,
      input  o_raddr,
      output i_rdata
   );
endinterface

// File: rtl/mem_dump_tx.sv
// ----------------------------------------------------------------------------
// mem_dump_tx
// Streams a contiguous range of memory words out of a UART TX pin, each word
// sent as four 8N1 frames, least significant byte first (the order the serial
// program loader consumes).
// Ports:
//   w_clk, r_rst : clock, synchronous active-high reset
//   i_start      : one-cycle command pulse, ignored while busy
//   i_base       : first word address (sampled at acceptance)
//   i_len        : number of words, 0..MEM_SIZE/4 (sampled at acceptance)
//   mem_if       : memory read port (o_ren / o_raddr / i_rdata)
//   o_txd        : registered UART line, idle high
//   o_busy       : dump in progress
//   o_done       : one-cycle completion pulse
// ----------------------------------------------------------------------------
module mem_dump_tx #(
   parameter int  MEM_SIZE    = 4096,
   parameter int  SERIAL_WCNT = 100,
   localparam int AW          = $clog2(MEM_SIZE) - 2
) (
   input  logic                w_clk,
   input  logic                r_rst,
   input  logic                i_start,
   input  logic [AW-1:0]       i_base,
   input  logic [AW:0]         i_len,
   mem_dump_tx_if.master       mem_if,
   output logic                o_txd,
   output logic                o_busy,
   output logic                o_done
);
   localparam int TW = $clog2(SERIAL_WCNT + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_SEND,
      ST_FIN
   } state_t;

   state_t        r_state,  w_state_next;
   logic [AW-1:0] r_base,   w_base_next;
   logic [AW:0]   r_len,    w_len_next;
   logic [AW:0]   r_idx,    w_idx_next;
   logic [31:0]   r_word,   w_word_next;
   logic [1:0]    r_bsel,   w_bsel_next;
   logic [3:0]    r_bit,    w_bit_next;
   logic [TW-1:0] r_tick,   w_tick_next;
   logic          r_txd,    w_txd_next;
   logic          r_done,   w_done_next;

   logic [7:0]    w_byte;
   logic [9:0]    w_frame;

   // Byte currently on the wire and its full 8N1 frame (bit 0 = start bit).
   assign w_byte  = 8'(r_word >> {r_bsel, 3'b000});
   assign w_frame = {1'b1, w_byte, 1'b0};

   assign mem_if.o_ren   = (r_state == ST_READ);
   assign mem_if.o_raddr = r_base + r_idx[AW-1:0];   // wraps at top of memory

   assign o_txd  = r_txd;
   assign o_done = r_done;
   // r_done trails the FIN state by one cycle so the pulse lines up with the
   // txd output register, i.e. it arrives after the final stop bit has left.
   assign o_busy = (r_state != ST_IDLE) || r_done;

   always_ff @(posedge w_clk) begin
      if (r_rst) begin
         r_state <= ST_IDLE;
         r_base  <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         r_word  <= '0;
         r_bsel  <= '0;
         r_bit   <= '0;
         r_tick  <= '0;
         r_txd   <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_base  <= w_base_next;
         r_len   <= w_len_next;
         r_idx   <= w_idx_next;
         r_word  <= w_word_next;
         r_bsel  <= w_bsel_next;
         r_bit   <= w_bit_next;
         r_tick  <= w_tick_next;
         r_txd   <= w_txd_next;
         r_done  <= w_done_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_base_next  = r_base;
      w_len_next   = r_len;
      w_idx_next   = r_idx;
      w_word_next  = r_word;
      w_bsel_next  = r_bsel;
      w_bit_next   = r_bit;
      w_tick_next  = r_tick;
      w_txd_next   = 1'b1;
      w_done_next  = (r_state == ST_FIN);

      case (r_state)
         ST_IDLE: begin
            // r_done still counts as busy, so a start during the done pulse
            // is dropped like any other start while busy.
            if (i_start && !r_done) begin
               w_base_next  = i_base;
               w_len_next   = i_len;
               w_idx_next   = '0;
               w_state_next = (i_len != '0) ? ST_READ : ST_FIN;
            end
         end
         ST_READ: begin
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            w_word_next  = mem_if.i_rdata;
            w_bsel_next  = '0;
            w_bit_next   = '0;
            w_tick_next  = '0;
            w_state_next = ST_SEND;
         end
         ST_SEND: begin
            w_txd_next = w_frame[r_bit];
            if (r_tick == TW'(SERIAL_WCNT - 1)) begin
               w_tick_next = '0;
               if (r_bit == 4'd9) begin
                  w_bit_next = '0;
                  if (r_bsel == 2'd3) begin
                     if (r_idx + (AW+1)'(1) < r_len) begin
                        w_idx_next   = r_idx + (AW+1)'(1);
                        w_state_next = ST_READ;
                     end else begin
                        w_state_next = ST_FIN;
                     end
                  end else begin
                     w_bsel_next = r_bsel + 2'd1;
                  end
               end else begin
                  w_bit_next = r_bit + 4'd1;
               end
            end else begin
               w_tick_next = r_tick + TW'(1);
            end
         end
         ST_FIN: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_mem_dump_tx.sv
// ----------------------------------------------------------------------------
// tb_mem_dump_tx
// Directed bench for mem_dump_tx (MEM_SIZE=64, SERIAL_WCNT=4). Every DUT
// output is logged once per cycle on the falling edge; each dump is then
// checked against the timeline worked out from the bench's memory image:
// read pulses/addresses, every frame sample, inter-word gaps, done position,
// busy length.
// ----------------------------------------------------------------------------
module tb_mem_dump_tx;
   localparam int MEM_SIZE = 64;
   localparam int WCNT     = 4;
   localparam int AW       = 4;
   localparam int NW       = MEM_SIZE / 4;
   localparam int WPER     = 4 * 10 * WCNT + 2;   // cycles between READ pulses
   localparam int LOGN     = 8192;

   logic          w_clk = 1'b0;
   logic          r_rst = 1'b1;
   logic          i_start = 1'b0;
   logic [AW-1:0] i_base = '0;
   logic [AW:0]   i_len = '0;
   logic          o_txd, o_busy, o_done;

   mem_dump_tx_if #(.AW(AW)) mem_if ();

   mem_dump_tx #(
      .MEM_SIZE    (MEM_SIZE),
      .SERIAL_WCNT (WCNT)
   ) dut (
      .w_clk   (w_clk),
      .r_rst   (r_rst),
      .i_start (i_start),
      .i_base  (i_base),
      .i_len   (i_len),
      .mem_if  (mem_if),
      .o_txd   (o_txd),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   always #5 w_clk = ~w_clk;

   // memory image with a synchronous read port
   logic [31:0] mem [NW];
   always @(posedge w_clk)
      if (mem_if.o_ren) mem_if.i_rdata <= mem[mem_if.o_raddr];

   int cyc = 0;
   always @(posedge w_clk) cyc <= cyc + 1;

   bit         txlog   [LOGN];
   bit         renlog  [LOGN];
   bit         donelog [LOGN];
   bit         busylog [LOGN];
   logic [3:0] addrlog [LOGN];
   always @(negedge w_clk) begin
      if (cyc < LOGN) begin
         txlog[cyc]   = o_txd;
         renlog[cyc]  = mem_if.o_ren;
         donelog[cyc] = o_done;
         busylog[cyc] = o_busy;
         addrlog[cyc] = mem_if.o_raddr;
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Called #1 after a posedge; drives a one-cycle start, returns its cycle.
   task automatic start_dump(input int base, input int len, output int s);
      i_start = 1'b1;
      i_base  = AW'(base);
      i_len   = (AW+1)'(len);
      s       = cyc;
      @(posedge w_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge w_clk); #1;
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) begin
         @(posedge w_clk); #1;
      end
   endtask

   function automatic int done_cycle(input int s, input int len);
      if (len == 0) return s + 2;
      return s + 3 + len * (40 * WCNT) + 2 * (len - 1) + 1;
   endfunction

   task automatic analyse(input string tag, input int s, input int base, input int len);
      int          done_c, n_ren, n_done, n_busy, a, st;
      logic [31:0] w;
      logic [7:0]  b;
      logic [9:0]  f;
      logic [39:0] obs, exp;
      logic [3:0]  pre;
      done_c = done_cycle(s, len);
      n_ren = 0; n_done = 0; n_busy = 0;
      for (int c = s; c <= done_c + 1; c++) begin
         n_ren  += int'(renlog[c]);
         n_done += int'(donelog[c]);
         n_busy += int'(busylog[c]);
      end
      $display("dump %s: base=%0d len=%0d start=%0d done_expected=%0d", tag, base, len, s, done_c);
      for (int k = 0; k < 4; k++) pre[k] = txlog[s + k];
      chk($sformatf("%s pre_idle", tag), pre, 4'hF);
      chk($sformatf("%s ren_count", tag), n_ren, len);
      for (int i = 0; i < len; i++) begin
         a = (base + i) % NW;
         chk($sformatf("%s ren_at_w%0d", tag, i), renlog[s + 1 + i * WPER], 1);
         chk($sformatf("%s raddr_w%0d", tag, i), addrlog[s + 1 + i * WPER], a);
         w = mem[a];
         for (int j = 0; j < 4; j++) begin
            b  = w[8*j +: 8];
            f  = {1'b1, b, 1'b0};
            st = s + 4 + i * WPER + j * 10 * WCNT;
            for (int k = 0; k < 40; k++) begin
               exp[k] = f[k / WCNT];
               obs[k] = txlog[st + k];
            end
            chk($sformatf("%s frame_w%0d_b%0d(%02h)", tag, i, j, b), obs, exp);
         end
         if (i < len - 1) begin
            st = s + 4 + i * WPER + 40 * WCNT;
            chk($sformatf("%s gap_w%0d", tag, i), {txlog[st], txlog[st + 1]}, 2'b11);
         end
      end
      chk($sformatf("%s done_count", tag), n_done, 1);
      chk($sformatf("%s done_at", tag), donelog[done_c], 1);
      chk($sformatf("%s busy_cycles", tag), n_busy, done_c - s);
      chk($sformatf("%s txd_at_done", tag), txlog[done_c], 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int s, s2, n_done, n_ren;
      for (int i = 0; i < NW; i++) mem[i] = 32'h10203040 + i * 32'h01010101;
      mem[0]  = 32'h44332211;
      mem[1]  = 32'h88776655;
      mem[2]  = 32'hA5C30F01;
      mem[3]  = 32'h00FF7E81;
      mem[4]  = 32'h13579BDF;
      mem[14] = 32'hDEADBEEF;
      mem[15] = 32'hCAFEF00D;

      // reset state
      run_cycles(3);
      chk("rst txd", o_txd, 1);
      chk("rst busy", o_busy, 0);
      chk("rst done", o_done, 0);
      chk("rst ren", mem_if.o_ren, 0);
      chk("rst raddr", mem_if.o_raddr, 0);
      r_rst = 1'b0;
      run_cycles(3);

      // single word
      start_dump(0, 1, s);
      run_to(done_cycle(s, 1) + 3);
      analyse("w1", s, 0, 1);
      run_cycles(3);

      // zero length
      start_dump(5, 0, s);
      run_to(done_cycle(s, 0) + 3);
      analyse("len0", s, 5, 0);
      run_cycles(3);

      // address wrap past top of memory
      start_dump(14, 4, s);
      run_to(done_cycle(s, 4) + 3);
      analyse("wrap", s, 14, 4);
      run_cycles(3);

      // start while busy is ignored; inputs sampled only at acceptance
      start_dump(0, 1, s);
      i_base = 4'd9;
      i_len  = 5'd3;
      run_cycles(48);
      i_start = 1'b1;
      i_base  = 4'd7;
      i_len   = 5'd2;
      run_cycles(1);
      i_start = 1'b0;
      run_to(done_cycle(s, 1) + 3);
      analyse("ignore", s, 0, 1);
      run_cycles(3);

      // reset during a zero data bit of byte 2 of word 0x88776655 (0x77, bit 3)
      start_dump(1, 1, s);
      run_cycles(100);
      r_rst = 1'b1;
      run_cycles(1);
      r_rst = 1'b0;
      run_cycles(60);
      $display("dump abort: base=1 len=1 start=%0d reset_cycle=%0d", s, s + 101);
      chk("abort txd_low_before", txlog[s + 101], 0);
      chk("abort busy_before", busylog[s + 101], 1);
      chk("abort txd_after", txlog[s + 102], 1);
      chk("abort busy_after", busylog[s + 102], 0);
      n_done = 0; n_ren = 0;
      for (int c = s + 1; c <= s + 160; c++) begin
         n_done += int'(donelog[c]);
         n_ren  += int'(renlog[c]);
      end
      chk("abort done_count", n_done, 0);
      chk("abort ren_count", n_ren, 1);
      start_dump(1, 2, s);
      run_to(done_cycle(s, 2) + 3);
      analyse("post_rst", s, 1, 2);
      run_cycles(3);

      // back-to-back: second start in the cycle after o_done
      start_dump(2, 1, s);
      run_cycles(164);
      start_dump(3, 2, s2);
      run_to(done_cycle(s2, 2) + 3);
      chk("b2b start_slot", s2, done_cycle(s, 1) + 1);
      analyse("b2b_a", s, 2, 1);
      analyse("b2b_b", s2, 3, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
